// File: rtl/mesh_pkg.sv
// Shared types for the mesh sequencer: FSM state encoding and the k-length width helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package mesh_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    STREAM = 3'd1,
    SKEW   = 3'd2,
    FLUSH  = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } mesh_seq_state_t;

  // Bits needed to hold an inner dimension in 0..k_max.
  function automatic int kw_width(input int k_max);
    return $clog2(k_max + 1);
  endfunction

endpackage

// File: rtl/skew_line.sv
// Fixed-depth register shift line used to stagger one mesh lane.
// Latency: DEPTH cycles (combinational pass-through when DEPTH=0).
// Backpressure: none; shifts every cycle.
// Ports: clk_i/rstn_i clock and async active-low reset, d_i lane input, q_o delayed lane output.
module skew_line #(
  parameter int DEPTH      = 1,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    // Lane 0 carries no delay; clock and reset are intentionally unused here.
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rstn_i;
    assign q_o = d_i;
  end else begin : g_shift
    logic [DEPTH-1:0][DATA_WIDTH-1:0] sr_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        sr_q <= '0;
      end else begin
        sr_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) begin
          sr_q[i] <= sr_q[i-1];
        end
      end
    end

    assign q_o = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/mesh_sequencer.sv
// Runs one tiled matmul pass on the NxN systolic mesh: streams K A/B beats with per-lane skew, then waits for mesh done/drain.
// Latency: ready 1 cycle after start; mesh_valid/last and lane-0 data 1 cycle after a fire, lane i a further i cycles.
// Backpressure: A and B fire together only when both valid while streaming; a stalled source injects zeros and holds the beat count.
// Ports: start_i/k_len_i/acc_sel_i command; a_*/b_* operand handshakes; mesh_* mesh controls and status; busy_o/done_o/error_o host status.
module mesh_sequencer
  import mesh_pkg::*;
#(
  parameter int  N          = 2,
  parameter int  DATA_WIDTH = 32,
  parameter int  K_MAX      = 256,
  parameter int  TIMEOUT    = 1024,
  localparam int KW         = kw_width(K_MAX)
) (
  input  logic                           clk_i,
  input  logic                           rstn_i,
  input  logic                           start_i,
  input  logic [KW-1:0]                  k_len_i,
  input  logic                           acc_sel_i,
  input  logic                           a_valid_i,
  output logic                           a_ready_o,
  input  logic [N-1:0][DATA_WIDTH-1:0]   a_data_i,
  input  logic                           b_valid_i,
  output logic                           b_ready_o,
  input  logic [N-1:0][DATA_WIDTH-1:0]   b_data_i,
  output logic [N-1:0][DATA_WIDTH-1:0]   mesh_west_o,
  output logic [N-1:0][DATA_WIDTH-1:0]   mesh_north_o,
  output logic                           mesh_valid_o,
  output logic                           mesh_last_o,
  output logic [N-1:0][N-1:0]            mesh_sel_acc_o,
  input  logic                           mesh_done_i,
  input  logic [N-1:0]                   mesh_drain_i,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           error_o
);

  // One counter serves both SKEW (N-1 cycles) and FLUSH (TIMEOUT cycles).
  localparam int CW = $clog2(TIMEOUT + N + 1);

  mesh_seq_state_t state_q, state_d;

  logic [KW-1:0]                 k_len_q;
  logic [KW-1:0]                 beat_cnt_q;
  logic [KW-1:0]                 beat_nxt;
  logic                          acc_sel_q;
  logic [CW-1:0]                 cyc_cnt_q;
  logic [N-1:0]                  drain_mask_q;
  logic                          mesh_done_q;
  logic                          error_q;
  logic                          done_q;
  logic                          valid_q;
  logic                          last_q;
  logic [N-1:0][DATA_WIDTH-1:0]  a_inj_q;
  logic [N-1:0][DATA_WIDTH-1:0]  b_inj_q;

  logic k_legal;
  logic start_ok;
  logic start_bad;
  logic fire;
  logic last_beat;
  logic skew_end;
  logic flush_done;
  logic flush_tmo;
  logic drain_full;

  assign k_legal    = (k_len_i != '0) && (int'(k_len_i) <= K_MAX);
  assign start_ok   = (state_q == IDLE) && start_i && k_legal;
  assign start_bad  = (state_q == IDLE) && start_i && !k_legal;
  assign fire       = (state_q == STREAM) && a_valid_i && b_valid_i;
  assign beat_nxt   = beat_cnt_q + KW'(1);
  assign last_beat  = fire && (beat_nxt == k_len_q);
  assign skew_end   = (state_q == SKEW) && (cyc_cnt_q == CW'(N - 2));
  // A registered mesh done takes priority over a timeout expiring in the same cycle.
  assign flush_done = (state_q == FLUSH) && mesh_done_q;
  assign flush_tmo  = (state_q == FLUSH) && !mesh_done_q && (cyc_cnt_q == CW'(TIMEOUT - 1));
  assign drain_full = (state_q == DRAIN) && (&drain_mask_q);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_ok)  state_d = STREAM;
      STREAM:  if (last_beat) state_d = (N > 1) ? SKEW : FLUSH;
      SKEW:    if (skew_end)  state_d = FLUSH;
      FLUSH: begin
        if (flush_done)     state_d = DRAIN;
        else if (flush_tmo) state_d = DONE;
      end
      DRAIN:   if (drain_full) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= IDLE;
      k_len_q      <= '0;
      beat_cnt_q   <= '0;
      acc_sel_q    <= 1'b0;
      cyc_cnt_q    <= '0;
      drain_mask_q <= '0;
      mesh_done_q  <= 1'b0;
      error_q      <= 1'b0;
      done_q       <= 1'b0;
      valid_q      <= 1'b0;
      last_q       <= 1'b0;
      a_inj_q      <= '0;
      b_inj_q      <= '0;
    end else begin
      state_q <= state_d;

      if (start_ok) begin
        k_len_q   <= k_len_i;
        acc_sel_q <= acc_sel_i;
      end

      if (start_ok)  beat_cnt_q <= '0;
      else if (fire) beat_cnt_q <= beat_nxt;

      // Restart the shared counter on every state change.
      if (state_d != state_q)
        cyc_cnt_q <= '0;
      else if ((state_q == SKEW) || (state_q == FLUSH))
        cyc_cnt_q <= cyc_cnt_q + CW'(1);

      if (start_ok)
        drain_mask_q <= '0;
      else if (state_q == DRAIN)
        drain_mask_q <= drain_mask_q | mesh_drain_i;

      mesh_done_q <= (state_q == FLUSH) && mesh_done_i;

      if (start_ok)                    error_q <= 1'b0;
      else if (start_bad || flush_tmo) error_q <= 1'b1;

      done_q  <= start_bad || (state_d == DONE);
      valid_q <= fire;
      last_q  <= last_beat;

      // Non-firing cycles push zeros so the skew lines never replay stale operands.
      a_inj_q <= fire ? a_data_i : '0;
      b_inj_q <= fire ? b_data_i : '0;
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_lane
    skew_line #(
      .DEPTH      (r),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_skew_a (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .d_i    (a_inj_q[r]),
      .q_o    (mesh_west_o[r])
    );

    skew_line #(
      .DEPTH      (r),
      .DATA_WIDTH (DATA_WIDTH)
    ) u_skew_b (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .d_i    (b_inj_q[r]),
      .q_o    (mesh_north_o[r])
    );
  end

  assign a_ready_o      = (state_q == STREAM);
  assign b_ready_o      = (state_q == STREAM);
  assign mesh_valid_o   = valid_q;
  assign mesh_last_o    = last_q;
  assign mesh_sel_acc_o = {(N * N){acc_sel_q}};
  assign busy_o         = (state_q != IDLE);
  assign done_o         = done_q;
  assign error_o        = error_q;

endmodule
